// File: rtl/image_mem_arbiter_pkg.sv
// Shared types and defaults for the image RAM arbiter.
package image_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_t;

    localparam int DEF_RAM_WIDTH     = 8;
    localparam int DEF_RAM_ADDR_BITS = 10;

endpackage

// File: rtl/image_mem_rr2.sv
// Two-way round-robin grant between the image writer and the pixel reader.
module image_mem_rr2
    import image_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic wr_req,
    input  logic rd_req,
    input  logic restart,
    output logic gnt_wr,
    output logic gnt_rd
);

    gnt_t last_grant;

    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (en) begin
            if (wr_req && rd_req) begin
                if (last_grant == GNT_RD) gnt_wr = 1'b1;
                else                      gnt_rd = 1'b1;
            end else begin
                gnt_wr = wr_req;
                gnt_rd = rd_req;
            end
        end
    end

    // Leaving a clear sequence restarts fairness as if from reset, so the writer goes first.
    always_ff @(posedge clk) begin
        if (reset || restart)
            last_grant <= GNT_RD;
        else if (gnt_wr)
            last_grant <= GNT_WR;
        else if (gnt_rd)
            last_grant <= GNT_RD;
    end

endmodule

// File: rtl/image_mem_arbiter.sv
// Image RAM controller: round-robin writer/reader sharing plus a full-RAM clear sweep.
module image_mem_arbiter
    import image_mem_arbiter_pkg::*;
#(
    parameter int                   RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int                   RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [RAM_ADDR_BITS-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]     wr_data,
    output logic                     wr_ready,
    input  logic                     rd_req,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic                     rd_ack,
    output logic                     rd_valid,
    output logic [RAM_WIDTH-1:0]     rd_data,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_addr,
    output logic [RAM_WIDTH-1:0]     mem_di,
    input  logic [RAM_WIDTH-1:0]     mem_do
);

    state_t                   state, next_state;
    logic [RAM_ADDR_BITS-1:0] clr_cnt;
    logic                     arb_en, gnt_wr, gnt_rd;

    // A clear request pre-empts arbitration in the cycle it arrives.
    assign arb_en = !reset && (state == IDLE) && !clear_req;

    image_mem_rr2 u_rr2 (
        .clk     (clk),
        .reset   (reset),
        .en      (arb_en),
        .wr_req  (wr_valid),
        .rd_req  (rd_req),
        .restart (state == DONE),
        .gnt_wr  (gnt_wr),
        .gnt_rd  (gnt_rd)
    );

    always_comb begin
        next_state = state;
        wr_ready   = 1'b0;
        rd_ack     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_di     = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        next_state = CLEAR;
                    end else begin
                        wr_ready = gnt_wr;
                        rd_ack   = gnt_rd;
                        mem_we   = gnt_wr;
                        if (gnt_wr) begin
                            mem_addr = wr_addr;
                            mem_di   = wr_data;
                        end else if (gnt_rd) begin
                            mem_addr = rd_addr;
                        end
                    end
                end
                CLEAR: begin
                    mem_we   = 1'b1;
                    mem_addr = clr_cnt;
                    mem_di   = CLEAR_VALUE;
                    if (clr_cnt == '1) next_state = DONE;
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= next_state;
            clr_cnt    <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            rd_valid   <= rd_ack;
            if (rd_ack) rd_data <= mem_do;
            busy       <= (next_state == CLEAR);
            clear_done <= (next_state == DONE);
        end
    end

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed self-checking bench for image_mem_arbiter with a behavioural 1K x 8 RAM.
module tb_image_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid, wr_ready, rd_req, rd_ack, rd_valid;
    logic [9:0] wr_addr, rd_addr, mem_addr;
    logic [7:0] wr_data, rd_data, mem_di, mem_do;
    logic       clear_req, busy, clear_done, mem_we;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_di;
    assign mem_do = ram[mem_addr];

    image_mem_arbiter #(
        .RAM_WIDTH     (8),
        .RAM_ADDR_BITS (10),
        .CLEAR_VALUE   (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_di     (mem_di),
        .mem_do     (mem_do)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d, input string tag);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        #1;
        chk(tag, {31'd0, wr_ready}, 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, input logic [7:0] exp, input string tag);
        rd_req = 1'b1; rd_addr = a;
        #1;
        chk({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
        tick();
        rd_req = 1'b0;
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  bad;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h11;
        reset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; clear_req = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        // Reset state; combinational outputs are forced low even with requests pending
        tick(); tick();
        wr_valid = 1'b1; rd_req = 1'b1; wr_addr = 10'h155; rd_addr = 10'h2AA; wr_data = 8'h77;
        #1;
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_di", {24'd0, mem_di}, 32'd0);
        wr_valid = 1'b0; rd_req = 1'b0;
        tick();
        reset = 1'b0;

        // Idle with nothing pending
        #1;
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        chk("idle_mem_addr", {22'd0, mem_addr}, 32'd0);

        // Single write then read-back
        wr_valid = 1'b1; wr_addr = 10'h003; wr_data = 8'hA5;
        #1;
        chk("w1_ready", {31'd0, wr_ready}, 32'd1);
        chk("w1_we", {31'd0, mem_we}, 32'd1);
        chk("w1_addr", {22'd0, mem_addr}, 32'h003);
        chk("w1_di", {24'd0, mem_di}, 32'hA5);
        chk("w1_no_ack", {31'd0, rd_ack}, 32'd0);
        tick();
        wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 10'h003;
        #1;
        chk("r1_ack", {31'd0, rd_ack}, 32'd1);
        chk("r1_we", {31'd0, mem_we}, 32'd0);
        chk("r1_addr", {22'd0, mem_addr}, 32'h003);
        chk("r1_valid_early", {31'd0, rd_valid}, 32'd0);
        tick();
        rd_req = 1'b0;
        chk("r1_valid", {31'd0, rd_valid}, 32'd1);
        chk("r1_data", {24'd0, rd_data}, 32'hA5);
        tick();
        chk("r1_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Contention from reset: WR, RD, WR, RD
        reset = 1'b1; tick(); reset = 1'b0;
        wr_valid = 1'b1; wr_addr = 10'h005; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr = 10'h003;
        #1;
        chk("rr1_wr", {30'd0, wr_ready, rd_ack}, 32'b10);
        tick(); #1;
        chk("rr2_rd", {30'd0, wr_ready, rd_ack}, 32'b01);
        chk("rr2_valid", {31'd0, rd_valid}, 32'd0);
        tick(); rd_addr = 10'h005; #1;
        chk("rr3_wr", {30'd0, wr_ready, rd_ack}, 32'b10);
        chk("rr3_valid", {31'd0, rd_valid}, 32'd1);
        chk("rr3_data", {24'd0, rd_data}, 32'hA5);
        tick(); #1;
        chk("rr4_rd", {30'd0, wr_ready, rd_ack}, 32'b01);
        chk("rr4_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        wr_valid = 1'b0; rd_req = 1'b0;
        chk("rr5_valid", {31'd0, rd_valid}, 32'd1);
        chk("rr5_data", {24'd0, rd_data}, 32'h3C);

        // Full clear with requests held throughout and a stray clear_req mid-sweep
        do_write(10'd0, 8'hFF, "pf0");
        do_write(10'd511, 8'hFF, "pf511");
        do_write(10'd1023, 8'hFF, "pf1023");
        wr_valid = 1'b1; wr_addr = 10'h077; wr_data = 8'h5A;
        rd_req = 1'b1; rd_addr = 10'd0;
        clear_req = 1'b1;
        #1;
        chk("clr_req_no_grant", {30'd0, wr_ready, rd_ack}, 32'd0);
        chk("clr_req_no_we", {31'd0, mem_we}, 32'd0);
        tick();
        n = 0; bad = 1'b0;
        while (busy === 1'b1 && n < 2000) begin
            clear_req = (n == 10);
            #1;
            if (wr_ready !== 1'b0 || rd_ack !== 1'b0 || mem_we !== 1'b1 ||
                mem_di !== 8'h00 || clear_done !== 1'b0 || mem_addr !== n[9:0]) bad = 1'b1;
            n++;
            tick();
        end
        clear_req = 1'b0;
        chk("clr_busy_cycles", n, 32'd1024);
        chk("clr_sweep_ok", {31'd0, bad}, 32'd0);
        #1;
        chk("clr_done_pulse", {31'd0, clear_done}, 32'd1);
        chk("clr_done_no_grant", {30'd0, wr_ready, rd_ack}, 32'd0);
        tick(); #1;
        chk("clr_done_drop", {31'd0, clear_done}, 32'd0);
        chk("post_clr_busy", {31'd0, busy}, 32'd0);
        chk("post_clr_wr_first", {30'd0, wr_ready, rd_ack}, 32'b10);
        chk("post_clr_wr_addr", {22'd0, mem_addr}, 32'h077);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("post_clr_rd", {31'd0, rd_ack}, 32'd1);
        tick();
        rd_req = 1'b0;
        chk("post_clr_rd0_valid", {31'd0, rd_valid}, 32'd1);
        chk("post_clr_rd0_data", {24'd0, rd_data}, 32'h00);
        chk("no_second_clear", {31'd0, busy}, 32'd0);
        do_read(10'd511, 8'h00, "clr511");
        do_read(10'd1023, 8'h00, "clr1023");
        do_read(10'h077, 8'h5A, "pend_wr");

        // Reset in the middle of a clear sweep
        do_write(10'd99, 8'hFF, "pf99");
        do_write(10'd200, 8'hFF, "pf200");
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        reset = 1'b1;
        #1;
        chk("abort_we_low", {31'd0, mem_we}, 32'd0);
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_no_done", {31'd0, clear_done}, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (clear_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("abort_quiet", {31'd0, bad}, 32'd0);
        do_read(10'd99, 8'h00, "abort99");
        do_read(10'd200, 8'hFF, "abort200");
        do_write(10'd300, 8'h42, "abort_idle_wr");
        do_read(10'd300, 8'h42, "abort_idle_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_mem_arbiter.md
Name: image_mem_arbiter

Overview:
Controller for the 1K x 8 single-port image RAM, which has a synchronous write and a combinational read. It shares the RAM between one write requester (image loader) and one read requester (pixel fetch), using round-robin arbitration with one access per cycle. It also provides a hardware clear sequence that fills the whole RAM with a constant. It sits between the requesters and the RAM, and is the only driver of the RAM's write_enable, addr and DI.

Parameters:
RAM_WIDTH, 8, data width of the RAM word
RAM_ADDR_BITS, 10, RAM address width; depth = 2**RAM_ADDR_BITS
CLEAR_VALUE, 8'h00, word written to every address during a clear sequence

Ports:
clk  in  1  single clock; every register is on its rising edge
reset  in  1  synchronous, active-high reset
wr_valid  in  1  writer has a word to store
wr_addr  in  RAM_ADDR_BITS  write address
wr_data  in  RAM_WIDTH  write data
wr_ready  out  1  write granted this cycle; transfer = wr_valid & wr_ready
rd_req  in  1  reader requests a word
rd_addr  in  RAM_ADDR_BITS  read address
rd_ack  out  1  read granted this cycle
rd_valid  out  1  registered; rd_data is valid this cycle
rd_data  out  RAM_WIDTH  registered read data
clear_req  in  1  single-cycle pulse; starts a full-RAM clear
busy  out  1  clear sequence in progress
clear_done  out  1  one-cycle pulse when the clear completes
mem_we  out  1  to RAM write_enable
mem_addr  out  RAM_ADDR_BITS  to RAM addr
mem_di  out  RAM_WIDTH  to RAM DI
mem_do  in  RAM_WIDTH  from RAM DO (combinational read)

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, clr_cnt = 0, last_grant = RD.
  - Registered outputs: rd_valid = 0, rd_data = 0, busy = 0, clear_done = 0.
  - Combinational outputs evaluate to 0 during reset: wr_ready, rd_ack, mem_we, mem_addr, mem_di.
- States: IDLE, CLEAR, DONE.
- IDLE arbitration (combinational grant, one per cycle):
  - Only wr_valid pending -> write grant.
  - Only rd_req pending -> read grant.
  - Both pending -> grant the side opposite to last_grant. last_grant updates on every grant.
  - Neither pending -> no grant, mem_we = 0, mem_addr = 0.
- Write grant:
  - wr_ready = 1, mem_we = 1, mem_addr = wr_addr, mem_di = wr_data.
  - The RAM word updates at the next clock edge.
  - wr_ready is never asserted while wr_valid = 0.
- Read grant:
  - rd_ack = 1, mem_we = 0, mem_addr = rd_addr.
  - On the next edge, rd_data <= mem_do and rd_valid <= 1. Latency is 1 cycle from ack to valid.
  - rd_valid is 0 in every cycle not following a read grant.
  - Requesters hold valid/req and addr/data stable until granted.
- Read-after-write to the same address on consecutive grants returns the new data.
- CLEAR entry:
  - clear_req = 1 in IDLE -> CLEAR on the next edge, clr_cnt = 0. The clear request takes priority over any pending read or write in that cycle; no grant is issued.
- CLEAR state:
  - busy = 1, mem_we = 1, mem_addr = clr_cnt, mem_di = CLEAR_VALUE; clr_cnt increments each cycle.
  - wr_ready = 0 and rd_ack = 0 throughout.
  - On clr_cnt = 2**RAM_ADDR_BITS - 1: that write completes, then -> DONE.
  - A full clear takes exactly 1024 cycles at default parameters.
- DONE: clear_done = 1 for one cycle, busy = 0, no grants. Then -> IDLE, with last_grant = RD.
- clear_req while in CLEAR or DONE is ignored; it is not queued.
- Reset during CLEAR aborts the sequence. Words not yet cleared keep their old contents, and clear_done is not pulsed.
- clr_cnt is RAM_ADDR_BITS wide; its wrap at the end of the sweep is not observable because the state changes.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2
  - grant encoding: GNT_RD = 1'b0, GNT_WR = 1'b1
  - defaults RAM_WIDTH = 8, RAM_ADDR_BITS = 10
- One natural sub-module: image_mem_rr2, a 2-way round-robin grant with the last_grant flop. The FSM and the clear counter stay in the top level.
- The bench instantiates the existing RAM block as the memory model.

Test Plan:
- Write 8'hA5 to addr 10'h003 (wr_valid only) -> wr_ready = 1 in the same cycle. Then read 10'h003 -> rd_ack, and next cycle rd_valid = 1 with rd_data = 8'hA5.
- wr_valid and rd_req held for 4 cycles, from reset -> grants alternate WR, RD, WR, RD. rd_valid follows each RD by 1 cycle.
- Pre-fill addrs 0, 511 and 1023 with 8'hFF, then pulse clear_req -> busy high for exactly 1024 cycles, then clear_done for 1 cycle. Reads of addrs 0, 511 and 1023 return 8'h00.
- During CLEAR, hold wr_valid and rd_req, and pulse clear_req again -> wr_ready = 0 and rd_ack = 0 throughout. No second clear occurs, and the pending write lands after DONE.
- Assert reset at clear cycle 100 -> next cycle busy = 0 and state is IDLE. Addr 99 = 8'h00, addr 200 keeps 8'hFF, and clear_done never pulses.
- Assert wr_valid and clear_req in the same IDLE cycle -> no grant that cycle. CLEAR starts, and the write is granted in the first IDLE cycle after DONE.
